poly_coef_bank: RTL and testbench
=================================

// Module: poly_coef_bank
// PURPOSE
//  Double-buffered float32 coefficient store feeding polynomial_estimator's tap reads.
//  Upstream (register/stream writer) loads G_POLY_ORDER+1 taps into a shadow bank.
//  On a complete load the shadow bank becomes active, but only while the estimator is idle.
//  The estimator reads the active bank by index; tap k = coefficient of x^k.
// PARAMETERS
//  G_POLY_ORDER  5   polynomial order; bank depth N+1 = G_POLY_ORDER+1
//  C_FP_DWIDTH   32  localparam, float32 word width
//  C_AWIDTH      -   localparam, $clog2(G_POLY_ORDER+1)
// PORTS
//  clk             in   1         single clock
//  reset           in   1         asynchronous, active-high
//  enable          in   1         0 = abort load, hold active bank
//  coef_din        in   32        float32 tap, written in index order 0..N
//  coef_din_valid  in   1         write handshake valid
//  coef_din_last   in   1         marks tap index N
//  coef_din_ready  out  1         write handshake ready
//  eval_busy       in   1         estimator mid-evaluation; blocks the bank swap
//  tap_rd_addr     in   C_AWIDTH  active-bank read index
//  tap_rd_data     out  32        registered read data, 1-cycle latency
//  coefs_valid     out  1         sticky: at least one full bank committed
//  bank_swapped    out  1         1-cycle pulse when the new bank goes active
//  load_error      out  1         1-cycle pulse on a malformed load
// BEHAVIOUR
//  Reset (async): both banks all 0x00000000; wr_ptr=0; active_sel=0; state SM_IDLE.
//   Outputs: tap_rd_data=0, coef_din_ready=0, coefs_valid=0, bank_swapped=0, load_error=0.
//  States:
//   SM_IDLE: go to SM_LOAD the cycle after enable=1.
//   SM_LOAD: coef_din_ready=1. Accept when valid&&ready: shadow[wr_ptr]<=coef_din.
//    - last=1 and wr_ptr==N: wr_ptr<=0, go SM_COMMIT_WAIT.
//    - last=1 and wr_ptr<N (early last), or last=0 and wr_ptr==N (missing last):
//      load_error pulses next cycle, wr_ptr<=0, stay SM_LOAD.
//      Partial shadow contents are don't-care.
//    - Otherwise wr_ptr++.
//   SM_COMMIT_WAIT: coef_din_ready=0. In any cycle with eval_busy==0:
//      active_sel<=~active_sel, bank_swapped<=1 (one cycle), coefs_valid<=1, go SM_LOAD.
//  Swap rule: eval_busy is sampled in the same cycle as the swap decision.
//   The estimator asserts eval_busy in the cycle it accepts din.
//   Therefore no swap lands mid-evaluation.
//  Reads: tap_rd_data <= active[tap_rd_addr] every cycle, independent of state and enable.
//   tap_rd_addr > N returns 0.
//   A read sampled on the swap edge returns the old bank; the new bank is visible from the next read.
//  enable=0 (synchronous, any state): state<=SM_IDLE, wr_ptr<=0, pending commit discarded.
//   Active bank, active_sel and coefs_valid are retained.
//  coefs_valid clears only on reset.
//  Words are stored bit-exact; no float interpretation, no NaN checks.
// STRUCTURE
//  poly_pkg: float_t (logic[31:0]), C_FP_DWIDTH, coef_bank_state_t enum.
//   Shared with polynomial_estimator.
//  Flat module, no sub-module: two float_t arrays [0:G_POLY_ORDER], indexed by active_sel.
// TESTING (G_POLY_ORDER=5)
//  1 Reset/readback: assert reset mid-run, then read addr 0..7.
//    -> all 0; coefs_valid=0; ready=0 in SM_IDLE, 1 from the second cycle after enable.
//  2 Normal load: 1.0..6.0 (0x3F800000..0x40C00000), last on 6th, eval_busy=0.
//    -> one bank_swapped pulse; addr2 reads 0x40400000; addr7 reads 0.
//  3 Early last on 3rd tap.
//    -> load_error one cycle; no swap; readback equals previous bank; next full load succeeds.
//  4 Busy hold: eval_busy=1 for 20 cycles after a full load.
//    -> ready=0, active bank unchanged; busy drops -> swap that cycle.
//  5 Valid gaps: random valid toggling during a load.
//    -> taps stored in order, no duplicates or skips.
//  6 Abort: enable=0 after 3 taps, then enable=1 and a full new load.
//    -> first tap lands at index 0; old bank readable throughout the abort.

Source files
------------

// File: rtl/poly_coef_bank_pkg.sv
// Shared types for the polynomial coefficient bank and its estimator:
// float32 word type, bank-loader state encoding and tap-address width helper.
package poly_coef_bank_pkg;

  localparam int C_FP_DWIDTH = 32;

  typedef logic [C_FP_DWIDTH-1:0] float_t;

  typedef enum logic [1:0] {
    SM_IDLE        = 2'd0,
    SM_LOAD        = 2'd1,
    SM_COMMIT_WAIT = 2'd2
  } coef_bank_state_t;

  // Address width for a bank of order+1 taps; never narrower than one bit.
  function automatic int tap_awidth(input int order);
    return (order < 1) ? 1 : $clog2(order + 1);
  endfunction

endpackage

// File: rtl/poly_coef_bank_if.sv
// Tap-load, tap-read and status signals between a coefficient writer/estimator
// (master) and the coefficient bank (slave).
interface poly_coef_bank_if
  import poly_coef_bank_pkg::*;
#(
  parameter int G_POLY_ORDER = 5
);
  localparam int C_AWIDTH = tap_awidth(G_POLY_ORDER);

  logic                enable;
  float_t              coef_din;
  logic                coef_din_valid;
  logic                coef_din_last;
  logic                coef_din_ready;
  logic                eval_busy;
  logic [C_AWIDTH-1:0] tap_rd_addr;
  float_t              tap_rd_data;
  logic                coefs_valid;
  logic                bank_swapped;
  logic                load_error;

  modport master (
    output enable, coef_din, coef_din_valid, coef_din_last, eval_busy, tap_rd_addr,
    input  coef_din_ready, tap_rd_data, coefs_valid, bank_swapped, load_error
  );

  modport slave (
    input  enable, coef_din, coef_din_valid, coef_din_last, eval_busy, tap_rd_addr,
    output coef_din_ready, tap_rd_data, coefs_valid, bank_swapped, load_error
  );

endinterface

// File: rtl/poly_coef_bank.sv
// Double-buffered float32 tap store: loads a shadow bank, swaps it active only while
// the estimator is idle, and serves registered 1-cycle reads of the active bank.
module poly_coef_bank
  import poly_coef_bank_pkg::*;
#(
  parameter int G_POLY_ORDER = 5
) (
  input  logic             clk,
  input  logic             reset,
  poly_coef_bank_if.slave  io_bus
);

  localparam int                  C_AWIDTH = tap_awidth(G_POLY_ORDER);
  localparam logic [C_AWIDTH-1:0] C_LAST   = C_AWIDTH'(G_POLY_ORDER);

  coef_bank_state_t    r_state;
  logic [C_AWIDTH-1:0] r_wr_ptr;
  logic                r_active_sel;
  float_t              r_bank0 [0:G_POLY_ORDER];
  float_t              r_bank1 [0:G_POLY_ORDER];
  float_t              r_rd_data;
  logic                r_coefs_valid;
  logic                r_bank_swapped;
  logic                r_load_error;

  coef_bank_state_t    w_state_nxt;
  logic [C_AWIDTH-1:0] w_wr_ptr_nxt;
  logic                w_ready;
  logic                w_accept;
  logic                w_swap;
  logic                w_err;
  logic                w_ptr_at_last;
  logic                w_addr_ok;
  logic [C_AWIDTH-1:0] w_rd_idx;
  float_t              w_active_word;

  assign w_ptr_at_last = (r_wr_ptr == C_LAST);
  assign w_addr_ok     = (io_bus.tap_rd_addr <= C_LAST);
  assign w_rd_idx      = w_addr_ok ? io_bus.tap_rd_addr : '0;
  assign w_active_word = r_active_sel ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];

  // enable=0 overrides every state; ready is gated so no word is taken during an abort.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_ready      = 1'b0;
    w_accept     = 1'b0;
    w_swap       = 1'b0;
    w_err        = 1'b0;
    if (!io_bus.enable) begin
      w_state_nxt  = SM_IDLE;
      w_wr_ptr_nxt = '0;
    end else begin
      case (r_state)
        SM_IDLE: w_state_nxt = SM_LOAD;
        SM_LOAD: begin
          w_ready  = 1'b1;
          w_accept = io_bus.coef_din_valid;
          if (w_accept) begin
            if (io_bus.coef_din_last && w_ptr_at_last) begin
              w_wr_ptr_nxt = '0;
              w_state_nxt  = SM_COMMIT_WAIT;
            end else if (io_bus.coef_din_last || w_ptr_at_last) begin
              w_err        = 1'b1;
              w_wr_ptr_nxt = '0;
            end else begin
              w_wr_ptr_nxt = r_wr_ptr + C_AWIDTH'(1);
            end
          end
        end
        SM_COMMIT_WAIT: begin
          if (!io_bus.eval_busy) begin
            w_swap      = 1'b1;
            w_state_nxt = SM_LOAD;
          end
        end
        default: w_state_nxt = SM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= SM_IDLE;
      r_wr_ptr       <= '0;
      r_active_sel   <= 1'b0;
      r_rd_data      <= '0;
      r_coefs_valid  <= 1'b0;
      r_bank_swapped <= 1'b0;
      r_load_error   <= 1'b0;
      for (int i = 0; i <= G_POLY_ORDER; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
    end else begin
      r_state        <= w_state_nxt;
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_bank_swapped <= w_swap;
      r_load_error   <= w_err;
      r_rd_data      <= w_addr_ok ? w_active_word : '0;
      if (w_swap) begin
        r_active_sel  <= ~r_active_sel;
        r_coefs_valid <= 1'b1;
      end
      // The shadow bank is whichever one is not active.
      if (w_accept) begin
        if (r_active_sel) r_bank0[r_wr_ptr] <= io_bus.coef_din;
        else              r_bank1[r_wr_ptr] <= io_bus.coef_din;
      end
    end
  end

  assign io_bus.coef_din_ready = w_ready;
  assign io_bus.tap_rd_data    = r_rd_data;
  assign io_bus.coefs_valid    = r_coefs_valid;
  assign io_bus.bank_swapped   = r_bank_swapped;
  assign io_bus.load_error     = r_load_error;

endmodule

// File: tb/tb_poly_coef_bank.sv
// Directed bench for poly_coef_bank (order 5): reset, load, malformed loads,
// busy-held swap, valid gaps, abort and discarded commit.
module tb_poly_coef_bank;
  import poly_coef_bank_pkg::*;

  localparam int N = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  float_t tv      [0:N];
  float_t exp_act [0:N];
  float_t old0;

  poly_coef_bank_if #(.G_POLY_ORDER(N)) bus ();

  poly_coef_bank #(.G_POLY_ORDER(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic write_tap(input float_t d, input logic last);
    int n;
    n = 0;
    bus.coef_din       = d;
    bus.coef_din_last  = last;
    bus.coef_din_valid = 1'b1;
    while (bus.coef_din_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("tap_ready_wait", 32'(n < 50), 32'd1);
    @(negedge clk);
    bus.coef_din_valid = 1'b0;
    bus.coef_din_last  = 1'b0;
    bus.coef_din       = 32'hDEAD_BEEF;
  endtask

  task automatic send_set(input bit with_last, input int max_gap);
    for (int k = 0; k <= N; k++) begin
      repeat ($urandom_range(0, max_gap)) begin
        bus.coef_din = $urandom;
        @(negedge clk);
      end
      write_tap(tv[k], with_last && (k == N));
    end
  endtask

  task automatic wait_swap(input string tag);
    int n;
    n = 0;
    while (bus.bank_swapped !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_swap_seen"}, 32'(n < 40), 32'd1);
    @(negedge clk);
    chk({tag, "_swap_1cyc"}, 32'(bus.bank_swapped), 32'd0);
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 8; a++) begin
      bus.tap_rd_addr = 3'(a);
      @(negedge clk);
      chk($sformatf("%s_rd%0d", tag, a), bus.tap_rd_data, (a <= N) ? exp_act[a] : 32'h0);
    end
  endtask

  task automatic set_tv(input float_t base);
    for (int k = 0; k <= N; k++) tv[k] = base + 32'(k * 3);
  endtask

  task automatic commit_tv();
    for (int k = 0; k <= N; k++) exp_act[k] = tv[k];
  endtask

  initial begin
    reset              = 1'b1;
    bus.enable         = 1'b0;
    bus.coef_din       = '0;
    bus.coef_din_valid = 1'b0;
    bus.coef_din_last  = 1'b0;
    bus.eval_busy      = 1'b0;
    bus.tap_rd_addr    = '0;
    for (int k = 0; k <= N; k++) exp_act[k] = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.coef_din_ready), 32'd0);
    chk("rst_valid", 32'(bus.coefs_valid), 32'd0);
    reset      = 1'b0;
    bus.enable = 1'b1;
    @(negedge clk);

    // Load something, then reset mid-run: everything must return to zero.
    set_tv(32'h1234_0000);
    send_set(1'b1, 0);
    wait_swap("pre");
    chk("pre_valid", 32'(bus.coefs_valid), 32'd1);
    #2 reset = 1'b1;
    bus.enable = 1'b0;
    @(negedge clk);
    chk("mid_rst_rd", bus.tap_rd_data, 32'h0);
    chk("mid_rst_valid", 32'(bus.coefs_valid), 32'd0);
    chk("mid_rst_swp", 32'(bus.bank_swapped), 32'd0);
    chk("mid_rst_err", 32'(bus.load_error), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_all("t1");
    chk("t1_idle_ready", 32'(bus.coef_din_ready), 32'd0);
    bus.enable = 1'b1;
    #1 chk("t1_en_cyc1_ready", 32'(bus.coef_din_ready), 32'd0);
    @(negedge clk);
    chk("t1_en_cyc2_ready", 32'(bus.coef_din_ready), 32'd1);

    // Normal load of 1.0 .. 6.0
    tv[0] = 32'h3F80_0000; tv[1] = 32'h4000_0000; tv[2] = 32'h4040_0000;
    tv[3] = 32'h4080_0000; tv[4] = 32'h40A0_0000; tv[5] = 32'h40C0_0000;
    send_set(1'b1, 0);
    chk("t2_commit_ready", 32'(bus.coef_din_ready), 32'd0);
    wait_swap("t2");
    chk("t2_valid", 32'(bus.coefs_valid), 32'd1);
    commit_tv();
    bus.tap_rd_addr = 3'd2;
    @(negedge clk);
    chk("t2_addr2", bus.tap_rd_data, 32'h4040_0000);
    bus.tap_rd_addr = 3'd7;
    @(negedge clk);
    chk("t2_addr7", bus.tap_rd_data, 32'h0);

    // Early last on the third tap
    write_tap(32'hAAAA_0000, 1'b0);
    write_tap(32'hAAAA_0001, 1'b0);
    write_tap(32'hAAAA_0002, 1'b1);
    chk("t3_err_pulse", 32'(bus.load_error), 32'd1);
    @(negedge clk);
    chk("t3_err_1cyc", 32'(bus.load_error), 32'd0);
    chk("t3_no_swap", 32'(bus.bank_swapped), 32'd0);
    check_all("t3_old");
    // Missing last: sixth tap without last
    set_tv(32'hBBBB_0000);
    send_set(1'b0, 0);
    chk("t3m_err_pulse", 32'(bus.load_error), 32'd1);
    @(negedge clk);
    chk("t3m_no_swap", 32'(bus.bank_swapped), 32'd0);
    set_tv(32'h4110_0000);
    send_set(1'b1, 0);
    wait_swap("t3");
    commit_tv();
    check_all("t3_new");

    // Busy hold for 20 cycles
    bus.tap_rd_addr = 3'd0;
    old0 = exp_act[0];
    bus.eval_busy = 1'b1;
    set_tv(32'h4220_0000);
    send_set(1'b1, 0);
    for (int c = 0; c < 20; c++) begin
      chk("t4_hold_swp", 32'(bus.bank_swapped), 32'd0);
      chk("t4_hold_rdy", 32'(bus.coef_din_ready), 32'd0);
      chk("t4_hold_rd", bus.tap_rd_data, old0);
      @(negedge clk);
    end
    bus.eval_busy = 1'b0;
    @(negedge clk);
    chk("t4_swap", 32'(bus.bank_swapped), 32'd1);
    chk("t4_swap_edge_rd", bus.tap_rd_data, old0);
    @(negedge clk);
    chk("t4_new_rd", bus.tap_rd_data, 32'h4220_0000);
    chk("t4_swap_1cyc", 32'(bus.bank_swapped), 32'd0);
    commit_tv();

    // Valid gaps
    set_tv(32'h4330_0100);
    send_set(1'b1, 3);
    wait_swap("t5");
    commit_tv();
    check_all("t5");

    // Abort after 3 taps
    set_tv(32'h5550_0000);
    write_tap(tv[0], 1'b0);
    write_tap(tv[1], 1'b0);
    write_tap(tv[2], 1'b0);
    bus.enable = 1'b0;
    #1 chk("t6_abort_ready", 32'(bus.coef_din_ready), 32'd0);
    check_all("t6_abort");
    chk("t6_valid_kept", 32'(bus.coefs_valid), 32'd1);
    chk("t6_no_err", 32'(bus.load_error), 32'd0);
    bus.enable = 1'b1;
    @(negedge clk);
    set_tv(32'h6660_0000);
    send_set(1'b1, 0);
    wait_swap("t6");
    commit_tv();
    check_all("t6_new");

    // Disable while a commit is pending: the commit is dropped
    bus.eval_busy = 1'b1;
    set_tv(32'h7770_0000);
    send_set(1'b1, 0);
    bus.enable = 1'b0;
    @(negedge clk);
    bus.eval_busy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t7_no_swap", 32'(bus.bank_swapped), 32'd0);
    end
    check_all("t7_old");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
